// File: rtl/touch_key_ctrl_if.sv
// touch_key_ctrl_if: touch-key input and LED/press outputs of touch_key_ctrl
interface touch_key_ctrl_if;
   logic touch_key;
   logic led_out;
   logic press_pulse;
   modport master (output touch_key, input led_out, press_pulse);
   modport slave (input touch_key, output led_out, press_pulse);
endinterface

// File: rtl/touch_key_ctrl.sv
// touch_key_ctrl: synchronise and debounce an active-low touch key, toggle led_out once per press
module touch_key_ctrl #(
   parameter int DEBOUNCE_CYCLES = 2,
   parameter int CNT_W = 16,
   parameter logic LED_INIT = 1'b0
) (
   input logic sys_clk,
   input logic sys_rst_n,
   touch_key_ctrl_if.slave k
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   logic sync_1, sync_2, key_filt, led_q, pulse_q;
   logic [CNT_W-1:0] cnt;
   // sys_rst_n is active-high despite its name
   always_ff @(posedge sys_clk) begin
      if (sys_rst_n) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
         key_filt <= 1'b1;
         cnt <= '0;
         pulse_q <= 1'b0;
         led_q <= LED_INIT;
      end else begin
         sync_1 <= k.touch_key;
         sync_2 <= sync_1;
         pulse_q <= 1'b0;
         if (sync_2 == key_filt) cnt <= '0;
         else if (cnt == CNT_LAST) begin
            key_filt <= sync_2;
            cnt <= '0;
            if (!sync_2) begin
               pulse_q <= 1'b1;
               led_q <= ~led_q;
            end
         end else cnt <= cnt + 1'b1;
      end
   end
   assign k.led_out = led_q;
   assign k.press_pulse = pulse_q;
endmodule

// File: tb/tb_touch_key_ctrl.sv
// tb_touch_key_ctrl: directed checks of touch_key_ctrl with DEBOUNCE_CYCLES=2, 20 ns clock
module tb_touch_key_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_cmp = 0;
   int n_err = 0;
   int pulses = 0;
   touch_key_ctrl_if k ();
   touch_key_ctrl #(.DEBOUNCE_CYCLES(2), .CNT_W(16), .LED_INIT(1'b0)) dut (
      .sys_clk(clk),
      .sys_rst_n(rst),
      .k(k.slave)
   );
   always #10 clk = ~clk;
   always @(negedge clk) if (k.press_pulse === 1'b1) pulses++;
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic chk_out(input string tag, input logic led, input logic pp, input int np);
      chk({tag, " led"}, int'(k.led_out), int'(led));
      chk({tag, " pulse"}, int'(k.press_pulse), int'(pp));
      if (np >= 0) chk({tag, " count"}, pulses, np);
   endtask
   initial begin
      k.touch_key = 1'b1;
      tick(2);
      chk_out("reset", 1'b0, 1'b0, -1);
      rst = 1'b0;
      tick(3);
      chk_out("idle", 1'b0, 1'b0, 0);
      k.touch_key = 1'b0;
      tick(1);
      chk_out("press k", 1'b0, 1'b0, -1);
      tick(1);
      chk_out("press k+1", 1'b0, 1'b0, -1);
      tick(1);
      chk_out("press k+2", 1'b0, 1'b0, -1);
      tick(1);
      chk_out("press k+3", 1'b1, 1'b1, 1);
      tick(1);
      chk_out("press k+4", 1'b1, 1'b0, 1);
      k.touch_key = 1'b1;
      tick(6);
      chk_out("release", 1'b1, 1'b0, 1);
      k.touch_key = 1'b0;
      tick(6);
      chk_out("second press", 1'b0, 1'b0, 2);
      k.touch_key = 1'b1;
      tick(1);
      k.touch_key = 1'b0;
      tick(6);
      chk_out("short release", 1'b0, 1'b0, 2);
      k.touch_key = 1'b1;
      tick(3);
      k.touch_key = 1'b0;
      tick(6);
      chk_out("third press", 1'b1, 1'b0, 3);
      k.touch_key = 1'b1;
      tick(6);
      k.touch_key = 1'b0;
      tick(1);
      k.touch_key = 1'b1;
      tick(6);
      chk_out("glitch", 1'b1, 1'b0, 3);
      for (int i = 0; i < 10; i++) begin
         k.touch_key = 1'b0;
         tick(1);
         k.touch_key = 1'b1;
         tick(1);
      end
      tick(6);
      chk_out("alternating", 1'b1, 1'b0, 3);
      k.touch_key = 1'b0;
      tick(1000);
      chk_out("long hold", 1'b0, 1'b0, 4);
      k.touch_key = 1'b1;
      tick(6);
      k.touch_key = 1'b0;
      tick(6);
      chk_out("pre reset", 1'b1, 1'b0, 5);
      rst = 1'b1;
      tick(1);
      chk_out("mid reset", 1'b0, 1'b0, 5);
      rst = 1'b0;
      tick(3);
      chk_out("post reset r+3", 1'b0, 1'b0, 5);
      tick(1);
      chk_out("post reset r+4", 1'b1, 1'b1, 6);
      tick(1);
      chk_out("post reset r+5", 1'b1, 1'b0, 6);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/touch_key_ctrl.md
Name: touch_key_ctrl

Overview:
- Conditions a capacitive touch-key input and toggles an LED output once per touch.
- Raw key is active-low: idle high, touched low.
- Input is synchronised, debounced, and falling-edge detected; each qualified press emits a one-cycle pulse and flips led_out.
- Sits between a board touch-sensor pin and an LED or downstream control logic.

Parameters:
- DEBOUNCE_CYCLES, 2: consecutive synchronised samples at the new level required before the filtered level changes; legal range 1..65535.
- CNT_W, 16: width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- LED_INIT, 0: value of led_out after reset.

Ports:
- sys_clk, input, 1: system clock; all logic rising-edge.
- sys_rst_n, input, 1: synchronous, active-high reset. Despite the _n suffix, 1 = reset, sampled on the sys_clk rising edge.
- touch_key, input, 1: raw touch sensor; asynchronous; 1 = idle, 0 = touched.
- led_out, output, 1: toggled state; flips once per qualified press.
- press_pulse, output, 1: one-cycle strobe on each qualified press.

Behaviour:
- Reset (sys_rst_n=1 at an edge):
  - sync_1, sync_2 and key_filt are set to 1 (idle).
  - Debounce counter is set to 0.
  - press_pulse is set to 0.
  - led_out is set to LED_INIT.
  - Reset has priority over all other updates.
- Synchroniser: two-flop chain; sync_1 <= touch_key, sync_2 <= sync_1. Only sync_2 feeds downstream logic.
- Debounce:
  - If sync_2 == key_filt, the counter is cleared to 0.
  - Otherwise the counter increments.
  - When sync_2 != key_filt and counter == DEBOUNCE_CYCLES-1, then at that edge key_filt <= sync_2 and the counter clears.
  - Any return to key_filt's value before that point clears the counter, so the glitch is rejected.
- Press detect:
  - At an edge where key_filt goes 1 to 0: press_pulse <= 1 and led_out <= ~led_out.
  - At every other edge press_pulse <= 0.
- Release: key_filt going 0 to 1 produces no pulse and no LED change.
- Latency: a low first sampled at edge k reaches sync_2 at edge k+1. key_filt falls, press_pulse rises and led_out toggles at edge k+DEBOUNCE_CYCLES+1.
- press_pulse is high for exactly one cycle per press, regardless of how long the key is held.
- Reset mid-press:
  - Filtered state returns to idle (1) and led_out returns to LED_INIT.
  - A key still held low after reset release is treated as a new press once debounced, giving one toggle.
- Key held low from before reset release: same handling, one toggle after the debounce latency.
- No counter overflow: the counter never exceeds DEBOUNCE_CYCLES-1.

Test Plan:
- Reset: assert sys_rst_n=1 for 2 cycles with touch_key=1 -> led_out=0, press_pulse=0; both remain 0 after release while touch_key stays 1.
- Single press (DEBOUNCE_CYCLES=2, 20 ns clock): touch_key low 100 ns, then high -> exactly one press_pulse (1 cycle), led_out 0 to 1 at 3 edges after the first low sample; no change on release.
- Re-press: after the single press, release for 20 ns, then hold low -> release is shorter than the debounce window and is rejected, so no further toggle (led_out stays 1). A release of 3 cycles or more followed by a press gives a second toggle (led_out 1 to 0).
- Glitch rejection: touch_key low for exactly 1 cycle (or lows separated by 1-cycle highs, DEBOUNCE_CYCLES=3) -> no press_pulse, led_out unchanged.
- Long hold: touch_key low for 1000 cycles -> exactly one press_pulse, led_out toggles once.
- Reset mid-press: with led_out=1 and key held low, pulse sys_rst_n=1 for 1 cycle -> led_out=0 immediately. After DEBOUNCE_CYCLES+1 further edges with key still low -> one pulse, led_out=1.
